// File: rtl/psram_opi_seq_if.sv
// Signal bundle between the PSRAM register front end, the OPI sequencer
// and the external PSRAM pins. The sequencer uses the slave modport.
interface psram_opi_seq_if;
    logic        en_i;
    logic [7:0]  pscr_i;
    logic [7:0]  cmd_rd_i;
    logic [7:0]  cmd_wr_i;
    logic [7:0]  wait_i;
    logic        xfer_valid_i;
    logic        xfer_ready_o;
    logic        xfer_we_i;
    logic [31:0] xfer_addr_i;
    logic [7:0]  xfer_len_i;
    logic        wdata_valid_i;
    logic        wdata_ready_o;
    logic [15:0] wdata_i;
    logic        rdata_valid_o;
    logic [15:0] rdata_o;
    logic        busy_o;
    logic        done_o;
    logic        psram_sck_o;
    logic        psram_ce_o;
    logic [7:0]  psram_io_en_o;
    logic [7:0]  psram_io_out_o;
    logic [7:0]  psram_io_in_i;
    logic        psram_dqs_en_o;
    logic        psram_dqs_out_o;
    logic        psram_dqs_in_i;

    modport slave (
        input  en_i, pscr_i, cmd_rd_i, cmd_wr_i, wait_i,
        input  xfer_valid_i, xfer_we_i, xfer_addr_i, xfer_len_i,
        input  wdata_valid_i, wdata_i, psram_io_in_i, psram_dqs_in_i,
        output xfer_ready_o, wdata_ready_o, rdata_valid_o, rdata_o,
        output busy_o, done_o, psram_sck_o, psram_ce_o,
        output psram_io_en_o, psram_io_out_o, psram_dqs_en_o, psram_dqs_out_o
    );

    modport master (
        output en_i, pscr_i, cmd_rd_i, cmd_wr_i, wait_i,
        output xfer_valid_i, xfer_we_i, xfer_addr_i, xfer_len_i,
        output wdata_valid_i, wdata_i, psram_io_in_i, psram_dqs_in_i,
        input  xfer_ready_o, wdata_ready_o, rdata_valid_o, rdata_o,
        input  busy_o, done_o, psram_sck_o, psram_ce_o,
        input  psram_io_en_o, psram_io_out_o, psram_dqs_en_o, psram_dqs_out_o
    );
endinterface

// File: rtl/psram_opi_seq.sv
// OPI octal-DDR burst sequencer: CMD, ADDR, LAT, DATA, TAIL and CEH phases,
// one sck edge per slot of P clk cycles, 16 bits per sck cycle.
module psram_opi_seq (
    input  logic           clk_i,
    input  logic           rst_i,
    psram_opi_seq_if.slave bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CMD  = 3'd1;
    localparam logic [2:0] S_ADDR = 3'd2;
    localparam logic [2:0] S_LAT  = 3'd3;
    localparam logic [2:0] S_DATA = 3'd4;
    localparam logic [2:0] S_TAIL = 3'd5;
    localparam logic [2:0] S_CEH  = 3'd6;

    logic [2:0]  r_state;
    logic [7:0]  r_h;
    logic [7:0]  r_p;
    logic [7:0]  r_half;
    logic [8:0]  r_slot;
    logic [7:0]  r_cmd;
    logic [7:0]  r_wait;
    logic [7:0]  r_len;
    logic [31:0] r_addr;
    logic        r_we;
    logic        r_sck;
    logic        r_ce;
    logic [7:0]  r_io_en;
    logic [7:0]  r_io_out;
    logic        r_dqs_en;
    logic        r_rvalid;
    logic [15:0] r_rdata;
    logic [7:0]  r_rlo;
    logic [7:0]  r_whi;
    logic        r_done;
    logic        r_busy;

    logic        w_idle;
    logic        w_ready;
    logic        w_accept;
    logic [7:0]  w_p_new;
    logic [8:0]  w_lat_slots;
    logic [8:0]  w_data_slots;
    logic        w_last_h;
    logic        w_even_wslot;
    logic        w_stall;
    logic        w_adv;
    logic        w_wtake;
    logic        w_rsample;
    logic        w_clocked;
    logic        w_sck_toggle;
    logic        w_last_slot;
    logic [2:0]  w_next_state;
    logic        w_unused_bits;

    assign w_idle       = (r_state == S_IDLE);
    assign w_ready      = bus.en_i & w_idle & ~rst_i;
    assign w_accept     = bus.xfer_valid_i & w_ready;
    assign w_p_new      = (bus.pscr_i < 8'd2) ? 8'd2 : bus.pscr_i;
    assign w_lat_slots  = {r_wait, 1'b0};
    assign w_data_slots = {1'b0, r_len};
    assign w_last_h     = (r_h == (r_p - 8'd1));

    // A write pair is fetched at the start of each even data slot; with no
    // word available the slot counter parks at h==0 and sck stays low.
    assign w_even_wslot = (r_state == S_DATA) & r_we & (r_h == 8'd0) & ~r_slot[0];
    assign w_stall      = w_even_wslot & ~bus.wdata_valid_i;
    assign w_wtake      = w_even_wslot & bus.wdata_valid_i & ~rst_i;
    assign w_adv        = ~w_idle & ~w_stall;
    assign w_rsample    = (r_state == S_DATA) & ~r_we & w_adv & w_last_h;
    assign w_clocked    = (r_state == S_CMD) | (r_state == S_ADDR) |
                          (r_state == S_LAT) | (r_state == S_DATA);
    assign w_sck_toggle = w_adv & w_clocked & (r_h == (r_half - 8'd1));

    assign w_unused_bits = bus.psram_dqs_in_i ^ bus.xfer_len_i[0];

    always_comb begin
        w_last_slot  = 1'b0;
        w_next_state = S_IDLE;
        case (r_state)
            S_CMD: begin
                w_last_slot  = (r_slot == 9'd1);
                w_next_state = S_ADDR;
            end
            S_ADDR: begin
                w_last_slot = (r_slot == 9'd3);
                if (r_wait != 8'd0)
                    w_next_state = S_LAT;
                else if (r_len != 8'd0)
                    w_next_state = S_DATA;
                else
                    w_next_state = S_TAIL;
            end
            S_LAT: begin
                w_last_slot  = (r_slot == (w_lat_slots - 9'd1));
                w_next_state = (r_len != 8'd0) ? S_DATA : S_TAIL;
            end
            S_DATA: begin
                w_last_slot  = (r_slot == (w_data_slots - 9'd1));
                w_next_state = S_TAIL;
            end
            S_TAIL: begin
                w_last_slot  = 1'b1;
                w_next_state = S_CEH;
            end
            S_CEH: begin
                w_last_slot  = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_last_slot  = 1'b0;
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Pin outputs are registered and loaded on the edge that opens a slot,
    // except the low write byte which follows the word fetch by one clk.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_h      <= 8'd0;
            r_p      <= 8'd2;
            r_half   <= 8'd1;
            r_slot   <= 9'd0;
            r_cmd    <= 8'd0;
            r_wait   <= 8'd0;
            r_len    <= 8'd0;
            r_addr   <= 32'd0;
            r_we     <= 1'b0;
            r_sck    <= 1'b0;
            r_ce     <= 1'b1;
            r_io_en  <= 8'h00;
            r_io_out <= 8'h00;
            r_dqs_en <= 1'b0;
            r_rvalid <= 1'b0;
            r_rdata  <= 16'h0000;
            r_rlo    <= 8'h00;
            r_whi    <= 8'h00;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_rvalid <= 1'b0;
            r_done   <= 1'b0;
            if (r_done)
                r_busy <= 1'b0;

            if (w_idle) begin
                if (w_accept) begin
                    r_state  <= S_CMD;
                    r_h      <= 8'd0;
                    r_slot   <= 9'd0;
                    r_p      <= w_p_new;
                    r_half   <= w_p_new >> 1;
                    r_cmd    <= bus.xfer_we_i ? bus.cmd_wr_i : bus.cmd_rd_i;
                    r_wait   <= bus.wait_i;
                    r_len    <= {bus.xfer_len_i[7:1], 1'b0};
                    r_addr   <= bus.xfer_addr_i;
                    r_we     <= bus.xfer_we_i;
                    r_ce     <= 1'b0;
                    r_io_out <= bus.xfer_we_i ? bus.cmd_wr_i : bus.cmd_rd_i;
                    r_io_en  <= 8'hFF;
                    r_busy   <= 1'b1;
                end
            end else if (w_adv) begin
                if (w_sck_toggle)
                    r_sck <= ~r_sck;
                if (!w_last_h) begin
                    r_h <= r_h + 8'd1;
                end else begin
                    r_h <= 8'd0;
                    if (w_last_slot) begin
                        r_state <= w_next_state;
                        r_slot  <= 9'd0;
                        case (w_next_state)
                            S_ADDR: r_io_out <= r_addr[31:24];
                            S_LAT:  r_io_en  <= 8'h00;
                            S_DATA: begin
                                r_io_en  <= r_we ? 8'hFF : 8'h00;
                                r_dqs_en <= r_we;
                            end
                            S_TAIL: begin
                                r_io_en  <= 8'h00;
                                r_io_out <= 8'h00;
                                r_dqs_en <= 1'b0;
                                r_sck    <= 1'b0;
                            end
                            S_CEH:  r_ce   <= 1'b1;
                            S_IDLE: r_done <= 1'b1;
                            default: ;
                        endcase
                    end else begin
                        r_slot <= r_slot + 9'd1;
                        if (r_state == S_ADDR) begin
                            case (r_slot[1:0])
                                2'd0:    r_io_out <= r_addr[23:16];
                                2'd1:    r_io_out <= r_addr[15:8];
                                default: r_io_out <= r_addr[7:0];
                            endcase
                        end
                        if ((r_state == S_DATA) && r_we && !r_slot[0])
                            r_io_out <= r_whi;
                    end
                end
            end

            if (w_wtake) begin
                r_io_out <= bus.wdata_i[7:0];
                r_whi    <= bus.wdata_i[15:8];
            end

            if (w_rsample) begin
                if (!r_slot[0]) begin
                    r_rlo <= bus.psram_io_in_i;
                end else begin
                    r_rdata  <= {bus.psram_io_in_i, r_rlo};
                    r_rvalid <= 1'b1;
                end
            end
        end
    end

    assign bus.xfer_ready_o    = w_ready;
    assign bus.wdata_ready_o   = w_wtake;
    assign bus.rdata_valid_o   = r_rvalid;
    assign bus.rdata_o         = r_rdata;
    assign bus.busy_o          = r_busy;
    assign bus.done_o          = r_done;
    assign bus.psram_sck_o     = r_sck;
    assign bus.psram_ce_o      = r_ce;
    assign bus.psram_io_en_o   = r_io_en;
    assign bus.psram_io_out_o  = r_io_out;
    assign bus.psram_dqs_en_o  = r_dqs_en;
    assign bus.psram_dqs_out_o = 1'b0;
endmodule

// File: tb/tb_psram_opi_seq.sv
// Directed self-checking bench for psram_opi_seq; cycle numbers count from
// the first clk with ce low (the clk after the request handshake).
module tb_psram_opi_seq;
    logic clk = 1'b0;
    logic rst;

    psram_opi_seq_if bus ();

    psram_opi_seq dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checkCount = 0;
    int failCount  = 0;

    logic [7:0]  togByte[$];
    logic [7:0]  togEn[$];
    logic        togDqs[$];
    int          risingCyc[$];
    logic [15:0] rdWords[$];
    int          rdCyc[$];
    logic        sckTrace[$];
    logic [7:0]  rdBytes[$];
    logic [15:0] wrWords[$];
    int          wrStall[$];
    logic        busyAtDone;
    logic        readyAtDone;
    logic        busyAfter;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issues one request from a negedge and returns at the negedge of cycle 0,
    // then scrambles the register inputs so latching is exercised.
    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [7:0] len,
                                 input logic [7:0] wt, input logic [7:0] pscr);
        bit ok;
        ok = 1'b0;
        bus.cmd_rd_i     = 8'hEE;
        bus.cmd_wr_i     = 8'hDE;
        bus.xfer_we_i    = we;
        bus.xfer_addr_i  = addr;
        bus.xfer_len_i   = len;
        bus.wait_i       = wt;
        bus.pscr_i       = pscr;
        bus.xfer_valid_i = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            #1;
            if (bus.xfer_ready_o) begin
                ok = 1'b1;
                @(posedge clk);
            end
            @(negedge clk);
        end
        bus.xfer_valid_i = 1'b0;
        bus.cmd_rd_i     = 8'h00;
        bus.cmd_wr_i     = 8'h00;
        bus.wait_i       = 8'd0;
        bus.pscr_i       = 8'd9;
        bus.xfer_addr_i  = 32'h0;
        bus.xfer_len_i   = 8'd0;
        checkOutput("handshake", {31'd0, ok}, 32'd1);
    endtask

    task automatic runBurst(input int p, input int base, input bit we, input int enDrop,
                            output int doneCyc);
        logic prevSck;
        int   taken;
        int   nextValid;
        int   k;
        prevSck   = 1'b0;
        taken     = 0;
        nextValid = 0;
        doneCyc   = -1;
        togByte.delete(); togEn.delete(); togDqs.delete(); risingCyc.delete();
        rdWords.delete(); rdCyc.delete(); sckTrace.delete();
        for (int c = 0; c < 3000; c++) begin
            sckTrace.push_back(bus.psram_sck_o);
            if (bus.psram_sck_o !== prevSck) begin
                togByte.push_back(bus.psram_io_out_o);
                togEn.push_back(bus.psram_io_en_o);
                togDqs.push_back(bus.psram_dqs_en_o);
                if (bus.psram_sck_o === 1'b1)
                    risingCyc.push_back(c);
                prevSck = bus.psram_sck_o;
            end
            if (bus.rdata_valid_o) begin
                rdWords.push_back(bus.rdata_o);
                rdCyc.push_back(c);
            end
            if (bus.done_o) begin
                doneCyc     = c;
                busyAtDone  = bus.busy_o;
                readyAtDone = bus.xfer_ready_o;
                break;
            end
            if (c == enDrop)
                bus.en_i = 1'b0;
            if (!we && c >= base) begin
                k = (c - base) / p;
                if (k < rdBytes.size())
                    bus.psram_io_in_i = rdBytes[k];
            end
            if (we) begin
                if (taken < wrWords.size() && c >= nextValid) begin
                    bus.wdata_valid_i = 1'b1;
                    bus.wdata_i       = wrWords[taken];
                end else begin
                    bus.wdata_valid_i = 1'b0;
                end
            end
            #1;
            if (we && bus.wdata_ready_o) begin
                taken++;
                if (taken < wrWords.size())
                    nextValid = c + 2 * p + wrStall[taken];
            end
            @(negedge clk);
        end
        bus.wdata_valid_i = 1'b0;
        @(negedge clk);
        busyAfter = bus.busy_o;
    endtask

    initial begin
        int d;
        int cnt;
        rst               = 1'b1;
        bus.en_i          = 1'b0;
        bus.pscr_i        = 8'd2;
        bus.cmd_rd_i      = 8'h00;
        bus.cmd_wr_i      = 8'h00;
        bus.wait_i        = 8'd0;
        bus.xfer_valid_i  = 1'b0;
        bus.xfer_we_i     = 1'b0;
        bus.xfer_addr_i   = 32'h0;
        bus.xfer_len_i    = 8'd0;
        bus.wdata_valid_i = 1'b0;
        bus.wdata_i       = 16'h0;
        bus.psram_io_in_i = 8'h00;
        bus.psram_dqs_in_i = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("rst_sck",      {31'd0, bus.psram_sck_o},     32'd0);
        checkOutput("rst_ce",       {31'd0, bus.psram_ce_o},      32'd1);
        checkOutput("rst_io_en",    {24'd0, bus.psram_io_en_o},   32'd0);
        checkOutput("rst_io_out",   {24'd0, bus.psram_io_out_o},  32'd0);
        checkOutput("rst_dqs_en",   {31'd0, bus.psram_dqs_en_o},  32'd0);
        checkOutput("rst_dqs_out",  {31'd0, bus.psram_dqs_out_o}, 32'd0);
        checkOutput("rst_rvalid",   {31'd0, bus.rdata_valid_o},   32'd0);
        checkOutput("rst_done",     {31'd0, bus.done_o},          32'd0);
        checkOutput("rst_busy",     {31'd0, bus.busy_o},          32'd0);
        checkOutput("rst_xready",   {31'd0, bus.xfer_ready_o},    32'd0);
        checkOutput("rst_wready",   {31'd0, bus.wdata_ready_o},   32'd0);

        rst = 1'b0;
        bus.xfer_valid_i = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("en0_xready", {31'd0, bus.xfer_ready_o}, 32'd0);
        checkOutput("en0_ce",     {31'd0, bus.psram_ce_o},   32'd1);
        bus.xfer_valid_i = 1'b0;
        bus.en_i = 1'b1;

        // Read: P=2, wait=5, len=4; data slots start at cycle 32
        rdBytes = {8'hA1, 8'hB2, 8'hC3, 8'hD4};
        applyStimulus(1'b0, 32'h0012_3456, 8'd4, 8'd5, 8'd2);
        runBurst(2, 32, 1'b0, -1, d);
        checkOutput("rd_cmd0",  {24'd0, togByte[0]}, 32'hEE);
        checkOutput("rd_cmd1",  {24'd0, togByte[1]}, 32'hEE);
        checkOutput("rd_addr0", {24'd0, togByte[2]}, 32'h00);
        checkOutput("rd_addr1", {24'd0, togByte[3]}, 32'h12);
        checkOutput("rd_addr2", {24'd0, togByte[4]}, 32'h34);
        checkOutput("rd_addr3", {24'd0, togByte[5]}, 32'h56);
        checkOutput("rd_addr_en", {24'd0, togEn[5]}, 32'hFF);
        cnt = 0;
        for (int i = 0; i < 16; i++)
            if (togEn[i] == 8'h00) cnt++;
        checkOutput("rd_lat_slots", cnt, 10);
        checkOutput("rd_nwords", rdWords.size(), 2);
        checkOutput("rd_word0", {16'd0, rdWords[0]}, 32'hB2A1);
        checkOutput("rd_word1", {16'd0, rdWords[1]}, 32'hD4C3);
        checkOutput("rd_valid0_cyc", rdCyc[0], 36);
        checkOutput("rd_valid1_cyc", rdCyc[1], 40);
        checkOutput("rd_done_cyc", d, 44);
        checkOutput("rd_busy_at_done", {31'd0, busyAtDone}, 32'd1);
        checkOutput("rd_ready_at_done", {31'd0, readyAtDone}, 32'd1);
        checkOutput("rd_busy_after", {31'd0, busyAfter}, 32'd0);

        // Write: P=2, wait=2, len=4; second word valid 3 clks late
        wrWords = {16'h2211, 16'h4433};
        wrStall = {0, 3};
        bus.wdata_i = 16'h2211;
        bus.wdata_valid_i = 1'b1;
        applyStimulus(1'b1, 32'h00AB_CD12, 8'd4, 8'd2, 8'd2);
        runBurst(2, 20, 1'b1, -1, d);
        checkOutput("wr_cmd0",  {24'd0, togByte[0]},  32'hDE);
        checkOutput("wr_addr2", {24'd0, togByte[4]},  32'hCD);
        checkOutput("wr_addr3", {24'd0, togByte[5]},  32'h12);
        checkOutput("wr_byte0", {24'd0, togByte[10]}, 32'h11);
        checkOutput("wr_byte1", {24'd0, togByte[11]}, 32'h22);
        checkOutput("wr_byte2", {24'd0, togByte[12]}, 32'h33);
        checkOutput("wr_byte3", {24'd0, togByte[13]}, 32'h44);
        checkOutput("wr_io_en", {24'd0, togEn[10]},   32'hFF);
        checkOutput("wr_dqs_en", {31'd0, togDqs[10]}, 32'd1);
        checkOutput("wr_stall_sck25", {31'd0, sckTrace[25]}, 32'd0);
        checkOutput("wr_stall_sck26", {31'd0, sckTrace[26]}, 32'd0);
        checkOutput("wr_done_cyc", d, 35);

        // pscr=0 behaves as pscr=2
        rdBytes = {8'h5A, 8'hC3};
        applyStimulus(1'b0, 32'h0000_0010, 8'd2, 8'd1, 8'd0);
        runBurst(2, 16, 1'b0, -1, d);
        checkOutput("p0_done_cyc", d, 24);
        checkOutput("p0_rise0", risingCyc[0], 1);
        checkOutput("p0_word", {16'd0, rdWords[0]}, 32'hC35A);
        checkOutput("p0_valid_cyc", rdCyc[0], 20);
        applyStimulus(1'b0, 32'h0000_0010, 8'd2, 8'd1, 8'd2);
        runBurst(2, 16, 1'b0, -1, d);
        checkOutput("p2_done_cyc", d, 24);
        checkOutput("p2_valid_cyc", rdCyc[0], 20);

        // pscr=5, wait=0, len=0: CMD+ADDR only
        applyStimulus(1'b0, 32'h0000_0002, 8'd0, 8'd0, 8'd5);
        runBurst(5, 0, 1'b0, -1, d);
        checkOutput("p5_done_cyc", d, 40);
        checkOutput("p5_rise0", risingCyc[0], 2);
        checkOutput("p5_rise1", risingCyc[1], 12);
        checkOutput("p5_nwords", rdWords.size(), 0);

        // len=3 moves two bytes
        rdBytes = {8'h5A, 8'hA5};
        applyStimulus(1'b0, 32'h0000_0020, 8'd3, 8'd0, 8'd2);
        runBurst(2, 12, 1'b0, -1, d);
        checkOutput("len3_nwords", rdWords.size(), 1);
        checkOutput("len3_word", {16'd0, rdWords[0]}, 32'hA55A);
        checkOutput("len3_done_cyc", d, 20);

        applyStimulus(1'b0, 32'h0000_0030, 8'd0, 8'd0, 8'd2);
        runBurst(2, 0, 1'b0, -1, d);
        checkOutput("len0_done_cyc", d, 16);
        checkOutput("len0_toggles", togByte.size(), 6);

        // Reset in the middle of DATA, then a normal burst
        applyStimulus(1'b0, 32'h0000_0040, 8'd8, 8'd1, 8'd2);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("mid_rst_ce",    {31'd0, bus.psram_ce_o},    32'd1);
        checkOutput("mid_rst_busy",  {31'd0, bus.busy_o},        32'd0);
        checkOutput("mid_rst_sck",   {31'd0, bus.psram_sck_o},   32'd0);
        checkOutput("mid_rst_io_en", {24'd0, bus.psram_io_en_o}, 32'd0);
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            if (bus.done_o) cnt++;
            @(negedge clk);
        end
        checkOutput("mid_rst_no_done", cnt, 0);
        rdBytes = {8'h01, 8'h02};
        applyStimulus(1'b0, 32'h0000_0080, 8'd2, 8'd0, 8'd2);
        runBurst(2, 12, 1'b0, -1, d);
        checkOutput("post_rst_done_cyc", d, 20);
        checkOutput("post_rst_word", {16'd0, rdWords[0]}, 32'h0201);

        // en_i dropped mid-burst: burst completes, nothing new accepted
        applyStimulus(1'b0, 32'h0000_0060, 8'd2, 8'd0, 8'd2);
        runBurst(2, 12, 1'b0, 3, d);
        checkOutput("endrop_done_cyc", d, 20);
        checkOutput("endrop_ready_at_done", {31'd0, readyAtDone}, 32'd0);
        bus.xfer_valid_i = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("endrop_xready", {31'd0, bus.xfer_ready_o}, 32'd0);
        checkOutput("endrop_ce",     {31'd0, bus.psram_ce_o},   32'd1);
        bus.xfer_valid_i = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end
endmodule
